// File: rtl/add_arbiter_if.sv
// Bundles the two requester ports and the shared result bus of add_arbiter.
// The master modport is the client side and the slave modport is the arbiter.
interface add_arbiter_if #(
   parameter int N = 6
);
   logic         req0;
   logic [N-1:0] a0;
   logic [N-1:0] b0;
   logic         req1;
   logic [N-1:0] a1;
   logic [N-1:0] b1;
   logic         gnt0;
   logic         gnt1;
   logic         busy;
   logic [N-1:0] sum;
   logic         carry;
   logic         valid;
   logic         owner;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  gnt0, gnt1, busy, sum, carry, valid, owner
   );

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output gnt0, gnt1, busy, sum, carry, valid, owner
   );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter that shares one N-bit ripple-carry adder between two requesters.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | sample req0/req1; on a grant latch operands, pulse gnt
//   CALC   | add latched operands, register sum/carry/owner, pulse valid
//   DONE   | recovery cycle, requests ignored, return to IDLE
module add_arbiter #(
   parameter int N = 6
) (
   input  logic           clk_i,
   input  logic           rst_i,
   add_arbiter_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]   state_q, state_d;
   logic         rr_q, rr_d;
   logic [N-1:0] opa_q, opa_d;
   logic [N-1:0] opb_q, opb_d;
   logic         own_q, own_d;
   logic         gnt0_q, gnt0_d;
   logic         gnt1_q, gnt1_d;
   logic         valid_q, valid_d;
   logic [N-1:0] sum_q, sum_d;
   logic         carry_q, carry_d;
   logic         owner_q, owner_d;

   logic [N-1:0] rc_sum;
   logic         rc_carry;
   logic         sel;

   // Bit-serial ripple chain over the latched operands, carry-in tied to 0.
   always_comb begin
      logic cy;
      cy     = 1'b0;
      rc_sum = '0;
      for (int i = 0; i < N; i++) begin
         rc_sum[i] = opa_q[i] ^ opb_q[i] ^ cy;
         cy        = (opa_q[i] & opb_q[i]) | (cy & (opa_q[i] ^ opb_q[i]));
      end
      rc_carry = cy;
   end

   // Arbitration and sequencing; gnt and valid default low so they only pulse.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      own_d   = own_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      owner_d = owner_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      valid_d = 1'b0;
      sel     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               sel     = (bus.req0 && bus.req1) ? rr_q : bus.req1;
               opa_d   = sel ? bus.a1 : bus.a0;
               opb_d   = sel ? bus.b1 : bus.b0;
               own_d   = sel;
               rr_d    = ~sel;
               gnt0_d  = ~sel;
               gnt1_d  = sel;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // owner is published together with the result, not at grant time
            sum_d   = rc_sum;
            carry_d = rc_carry;
            owner_d = own_q;
            valid_d = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset drops any add in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rr_q    <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         own_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         own_q   <= own_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         owner_q <= owner_d;
      end
   end

   assign bus.gnt0  = gnt0_q;
   assign bus.gnt1  = gnt1_q;
   assign bus.busy  = (state_q != S_IDLE);
   assign bus.sum   = sum_q;
   assign bus.carry = carry_q;
   assign bus.valid = valid_q;
   assign bus.owner = owner_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level timing model.
module tb_add_arbiter;

   localparam int N = 6;

   logic clk;
   logic rst;

   add_arbiter_if #(.N(N)) bus ();

   add_arbiter #(.N(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: an add granted at edge g yields gnt at g, the result at
   // g+1, and the arbiter may take the next request no earlier than edge g+3.
   int   edge_no     = 0;
   int   next_sample = 0;
   bit   m_rr        = 0;
   bit   pend        = 0;
   int   pend_a, pend_b;
   bit   pend_own;
   bit   m_gnt0, m_gnt1, m_valid, m_busy, m_carry, m_owner;
   int   m_sum;

   task automatic model_edge();
      int k;
      int s;
      if (rst) begin
         m_gnt0 = 0; m_gnt1 = 0; m_valid = 0; m_busy = 0;
         m_sum = 0; m_carry = 0; m_owner = 0;
         m_rr = 0; pend = 0;
         next_sample = edge_no + 1;
      end else begin
         m_gnt0 = 0; m_gnt1 = 0; m_valid = 0;
         if (pend) begin
            s       = pend_a + pend_b;
            m_sum   = s % (1 << N);
            m_carry = (s >= (1 << N));
            m_owner = pend_own;
            m_valid = 1;
            pend    = 0;
         end
         if (edge_no >= next_sample && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) k = m_rr;
            else                      k = bus.req1 ? 1 : 0;
            pend_a   = (k == 1) ? int'(bus.a1) : int'(bus.a0);
            pend_b   = (k == 1) ? int'(bus.b1) : int'(bus.b0);
            pend_own = (k == 1);
            pend     = 1;
            m_rr     = (k == 0);
            m_gnt0   = (k == 0);
            m_gnt1   = (k == 1);
            next_sample = edge_no + 3;
         end
         m_busy = (edge_no < next_sample - 1);
      end
      edge_no++;
   endtask

   // One clock: model sees the same inputs the DUT samples, outputs checked 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("gnt0",  bus.gnt0,  m_gnt0);
      check("gnt1",  bus.gnt1,  m_gnt1);
      check("valid", bus.valid, m_valid);
      check("busy",  bus.busy,  m_busy);
      check("sum",   bus.sum,   m_sum);
      check("carry", bus.carry, m_carry);
      check("owner", bus.owner, m_owner);
      check("gnt_excl",  bus.gnt0 & bus.gnt1, 0);
      check("valid_gnt", bus.valid & (bus.gnt0 | bus.gnt1), 0);
   endtask

   task automatic set_req(input bit r0, input int xa0, input int xb0,
                          input bit r1, input int xa1, input int xb1);
      bus.req0 = r0; bus.a0 = xa0[N-1:0]; bus.b0 = xb0[N-1:0];
      bus.req1 = r1; bus.a1 = xa1[N-1:0]; bus.b1 = xb1[N-1:0];
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_req(0, 0, 0, 0, 0, 0);

      // reset then idle
      do_reset(2);
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_busy", bus.busy, 0);
         check("idle_sum",  bus.sum,  0);
      end

      // single add 25+30 by requester 0
      set_req(1, 25, 30, 0, 0, 0);
      step();
      check("e0_gnt0", bus.gnt0, 1);
      set_req(0, 0, 0, 0, 0, 0);
      step();
      check("e1_valid", bus.valid, 1);
      check("e1_sum",   bus.sum,   55);
      check("e1_carry", bus.carry, 0);
      check("e1_owner", bus.owner, 0);
      step();
      check("e2_valid", bus.valid, 0);
      check("e2_busy",  bus.busy,  0);

      // overflow cases on requester 1
      set_req(0, 0, 0, 1, 40, 40);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      step();
      check("ovf_sum",   bus.sum,   16);
      check("ovf_carry", bus.carry, 1);
      check("ovf_owner", bus.owner, 1);
      step();
      set_req(0, 0, 0, 1, 63, 1);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      step();
      check("wrap_sum",   bus.sum,   0);
      check("wrap_carry", bus.carry, 1);
      step();

      // sustained double request from reset, operands scrambled every cycle
      do_reset(1);
      set_req(1, 11, 7, 1, 50, 20);
      for (int i = 0; i < 12; i++) begin
         step();
         if (i % 3 == 0) check("rr_order", bus.gnt1, (i / 3) % 2);
         set_req(1, $urandom_range(0, 63), $urandom_range(0, 63),
                 1, $urandom_range(0, 63), $urandom_range(0, 63));
      end
      set_req(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step();

      // reset while in CALC, leaving rr pointing at requester 1 beforehand
      set_req(1, 5, 6, 0, 0, 0);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_valid", bus.valid, 0);
      check("rst_busy",  bus.busy,  0);
      check("rst_sum",   bus.sum,   0);
      set_req(1, 3, 4, 1, 9, 9);
      step();
      check("rst_tie_gnt0", bus.gnt0, 1);
      set_req(0, 0, 0, 0, 0, 0);
      step();
      step();

      // request arriving while busy
      set_req(1, 1, 2, 0, 0, 0);
      step();
      set_req(0, 0, 0, 1, 12, 13);
      step();
      check("busy_no_gnt1_calc", bus.gnt1, 0);
      step();
      check("busy_no_gnt1_done", bus.gnt1, 0);
      step();
      check("busy_gnt1", bus.gnt1, 1);
      set_req(0, 0, 0, 0, 0, 0);
      step();
      check("busy_sum", bus.sum, 25);
      step();

      // random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         set_req($urandom_range(0, 2) == 0, $urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 63), $urandom_range(0, 63));
         rst = ($urandom_range(0, 39) == 0);
         step();
      end
      rst = 1'b0;
      set_req(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
